// File: rtl/layer_sequencer.sv
// Layer sequencer: streams an input vector into a serial layer datapath,
// runs N_LAYERS passes with feedback, then drains the result vector out.
// Each pass is a frame of SIZE+1 slots: slot 0 clears the accumulator,
// slots 1..SIZE carry one data word each.
module layer_sequencer #(
  parameter int SIZE     = 3,
  parameter int BIT_SIZE = 1,
  parameter int N_LAYERS = 2,
  localparam int AW = (N_LAYERS * SIZE > 1) ? $clog2(N_LAYERS * SIZE) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] in_data,
  input  logic [BIT_SIZE-1:0] y_in,
  output logic [BIT_SIZE-1:0] lyr_x,
  output logic                lyr_sel,
  output logic                lyr_clr,
  output logic                lyr_en,
  output logic [AW-1:0]       w_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] out_data,
  output logic                busy,
  output logic                done
);

  localparam int SW = $clog2(SIZE + 1);
  localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SIZE);
  localparam logic [LW-1:0] LAYER_LAST = LW'(N_LAYERS - 1);
  localparam logic [AW-1:0] LAYER_STEP = AW'(SIZE);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [SW-1:0]       slot_reg, slot_next;
  logic [LW-1:0]       layer_reg, layer_next;
  // base_reg tracks layer_reg*SIZE incrementally so no multiplier is needed
  logic [AW-1:0]       base_reg, base_next;
  logic                hold_valid_reg;
  logic [BIT_SIZE-1:0] hold_data_reg;

  logic          data_slot;
  logic          last_slot;
  logic          advance;
  logic [SW-1:0] slot_m1;
  logic [AW-1:0] slot_addr;

  assign data_slot = (slot_reg != '0);
  assign last_slot = (slot_reg == SLOT_LAST);
  assign slot_m1   = slot_reg - SW'(1);
  // Slot 0 presents the first address of the layer so it is ready early
  assign slot_addr = data_slot ? (base_reg + AW'(slot_m1)) : base_reg;

  // State, slot and layer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      slot_reg  <= '0;
      layer_reg <= '0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      layer_reg <= layer_next;
      base_reg  <= base_next;
    end
  end

  // Captures the presented result word on a stall so out_data stays put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else if (out_valid && out_ready) begin
      hold_valid_reg <= 1'b0;
    end else if (out_valid && !hold_valid_reg) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= y_in;
    end
  end

  // Next-state and output decode; outputs default to their reset values
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    layer_next = layer_reg;
    base_next  = base_reg;
    advance    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    lyr_sel    = 1'b0;
    lyr_en     = 1'b0;
    lyr_clr    = 1'b1;
    w_addr     = '0;
    lyr_x      = '0;
    out_data   = '0;

    // While reset is held every output shows its reset value immediately
    if (rst_n) begin
      case (state_reg)
        IDLE: begin
          lyr_en = 1'b1;
          if (start) begin
            state_next = LOAD;
            slot_next  = '0;
            layer_next = '0;
            base_next  = '0;
          end
        end

        LOAD: begin
          busy    = 1'b1;
          lyr_sel = 1'b1;
          lyr_clr = !data_slot;
          w_addr  = slot_addr;
          if (data_slot) begin
            in_ready = 1'b1;
            lyr_x    = in_data;
            lyr_en   = in_valid;
            advance  = in_valid;
          end else begin
            lyr_en  = 1'b1;
            advance = 1'b1;
          end
          if (advance) begin
            if (last_slot) begin
              slot_next = '0;
              if (N_LAYERS > 1) begin
                state_next = COMPUTE;
                layer_next = LW'(1);
                base_next  = base_reg + LAYER_STEP;
              end else begin
                state_next = DRAIN;
              end
            end else begin
              slot_next = slot_reg + SW'(1);
            end
          end
        end

        COMPUTE: begin
          busy    = 1'b1;
          lyr_en  = 1'b1;
          lyr_clr = !data_slot;
          w_addr  = slot_addr;
          if (last_slot) begin
            slot_next = '0;
            if (layer_reg == LAYER_LAST) begin
              state_next = DRAIN;
            end else begin
              layer_next = layer_reg + LW'(1);
              base_next  = base_reg + LAYER_STEP;
            end
          end else begin
            slot_next = slot_reg + SW'(1);
          end
        end

        DRAIN: begin
          busy    = 1'b1;
          lyr_clr = !data_slot;
          w_addr  = slot_addr;
          if (data_slot) begin
            out_valid = 1'b1;
            out_data  = hold_valid_reg ? hold_data_reg : y_in;
            lyr_en    = out_ready;
            advance   = out_ready;
          end else begin
            lyr_en  = 1'b1;
            advance = 1'b1;
          end
          if (advance) begin
            if (last_slot) begin
              slot_next  = '0;
              state_next = DONE;
            end else begin
              slot_next = slot_reg + SW'(1);
            end
          end
        end

        DONE: begin
          done   = 1'b1;
          lyr_en = 1'b1;
          slot_next  = '0;
          layer_next = '0;
          base_next  = '0;
          state_next = start ? LOAD : IDLE;
        end

        default: begin
          state_next = IDLE;
          slot_next  = '0;
          layer_next = '0;
          base_next  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a per-cycle vector table for the
// nominal inference plus hand-written stall, reset, restart and
// single-layer sequences.
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start1;
  logic       in_valid, out_ready;
  logic [0:0] in_data, y_in;

  logic       in_ready, lyr_sel, lyr_clr, lyr_en, out_valid, busy, done;
  logic [0:0] lyr_x, out_data;
  logic [2:0] w_addr;

  logic       in_ready1, lyr_sel1, lyr_clr1, lyr_en1, out_valid1, busy1, done1;
  logic [0:0] lyr_x1, out_data1;
  logic [1:0] w_addr1;

  int checks = 0;
  int errors = 0;

  layer_sequencer #(.SIZE(3), .BIT_SIZE(1), .N_LAYERS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .y_in(y_in), .lyr_x(lyr_x), .lyr_sel(lyr_sel), .lyr_clr(lyr_clr),
    .lyr_en(lyr_en), .w_addr(w_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  layer_sequencer #(.SIZE(3), .BIT_SIZE(1), .N_LAYERS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .y_in(y_in), .lyr_x(lyr_x1), .lyr_sel(lyr_sel1), .lyr_clr(lyr_clr1),
    .lyr_en(lyr_en1), .w_addr(w_addr1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  // flags order: busy, done, in_ready, out_valid, lyr_sel, lyr_clr, lyr_en
  typedef struct {
    logic       st;
    logic       iv;
    logic       id;
    logic       ordy;
    logic       yi;
    logic [6:0] flags;
    int         addr;  // -1: not checked
    int         x;     // -1: not checked
    int         od;    // -1: not checked
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic st, input logic id, input logic yi,
                              input logic [6:0] flags, input int addr,
                              input int x, input int od);
    vec_t v;
    v.st = st; v.iv = 1'b1; v.id = id; v.ordy = 1'b1; v.yi = yi;
    v.flags = flags; v.addr = addr; v.x = x; v.od = od;
    return v;
  endfunction

  function automatic int flags_now();
    return int'({busy, done, in_ready, out_valid, lyr_sel, lyr_clr, lyr_en});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, " flags"}, flags_now(), 7'b0000010);
    chk({name, " w_addr"}, int'(w_addr), 0);
    chk({name, " lyr_x"}, int'(lyr_x), 0);
    chk({name, " out_data"}, int'(out_data), 0);
  endtask

  task automatic apply_table();
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      start = tbl[i].st; in_valid = tbl[i].iv; in_data = tbl[i].id;
      out_ready = tbl[i].ordy; y_in = tbl[i].yi;
      @(negedge clk);
      chk($sformatf("tbl%0d flags", i), flags_now(), int'(tbl[i].flags));
      if (tbl[i].addr >= 0) chk($sformatf("tbl%0d w_addr", i), int'(w_addr), tbl[i].addr);
      if (tbl[i].x >= 0)    chk($sformatf("tbl%0d lyr_x", i), int'(lyr_x), tbl[i].x);
      if (tbl[i].od >= 0)   chk($sformatf("tbl%0d out_data", i), int'(out_data), tbl[i].od);
      $display("tbl row %0d flags=%b w_addr=%0d", i, flags_now(), w_addr);
    end
  endtask

  // One inference on the main DUT with optional stall windows and an
  // extra start pulse; exp_lat counts cycles from the start cycle to done.
  task automatic run_case(input string name, input int in_at, input int in_len,
                          input int out_at, input int out_len, input int again_at,
                          input int exp_lat, input bit restart);
    int lat = -1;
    int held = out_at % 2;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      start     = (c == 0) || (c == again_at);
      in_valid  = !(c >= in_at && c < in_at + in_len);
      out_ready = !(c >= out_at && c < out_at + out_len);
      in_data   = 1'(~c[0]);
      y_in      = 1'(c[0]);
      @(negedge clk);
      if (c >= in_at && c < in_at + in_len) begin
        chk({name, " in-stall lyr_en"}, int'(lyr_en), 0);
        chk({name, " in-stall w_addr"}, int'(w_addr), 1);
        chk({name, " in-stall in_ready"}, int'(in_ready), 1);
      end
      if (c >= out_at && c < out_at + out_len) begin
        chk({name, " out-stall out_valid"}, int'(out_valid), 1);
        chk({name, " out-stall out_data"}, int'(out_data), held);
        chk({name, " out-stall lyr_en"}, int'(lyr_en), 0);
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    chk({name, " latency"}, lat, exp_lat);
    $display("seq %s latency %0d", name, lat);
    if (restart) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk({name, " restart flags"}, flags_now(), 7'b1000111);
      lat = -1;
      for (int c = 1; c < 60; c++) begin
        if (done) begin
          lat = c - 1;
          break;
        end
        @(posedge clk); #1;
        @(negedge clk);
      end
      // cycle counted from the DONE cycle that carried the start
      chk({name, " restart latency"}, lat + 1, 13);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({name, " after done"}, int'({busy, done}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tbl[0]  = mk(1, 1, 1, 7'b0000011, -1, -1, -1);
    tbl[1]  = mk(0, 1, 1, 7'b1000111, -1, -1, -1);
    tbl[2]  = mk(0, 1, 1, 7'b1010101,  0,  1, -1);
    tbl[3]  = mk(0, 0, 1, 7'b1010101,  1,  0, -1);
    tbl[4]  = mk(0, 1, 1, 7'b1010101,  2,  1, -1);
    tbl[5]  = mk(0, 1, 1, 7'b1000011, -1, -1, -1);
    tbl[6]  = mk(0, 1, 1, 7'b1000001,  3, -1, -1);
    tbl[7]  = mk(0, 1, 1, 7'b1000001,  4, -1, -1);
    tbl[8]  = mk(0, 1, 1, 7'b1000001,  5, -1, -1);
    tbl[9]  = mk(0, 1, 1, 7'b1000011, -1, -1, -1);
    tbl[10] = mk(0, 1, 1, 7'b1001001, -1, -1,  1);
    tbl[11] = mk(0, 1, 0, 7'b1001001, -1, -1,  0);
    tbl[12] = mk(0, 1, 1, 7'b1001001, -1, -1,  1);
    tbl[13] = mk(0, 1, 1, 7'b0100011, -1, -1, -1);
    tbl[14] = mk(0, 1, 1, 7'b0000011, -1, -1, -1);

    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; in_data = 1'b1; y_in = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_reset("reset");
    rst_n = 1'b1;

    apply_table();

    run_case("load-stall", 3, 2, -1, 0, -1, 15, 1'b0);
    run_case("drain-stall", -1, 0, 10, 3, -1, 16, 1'b0);
    run_case("start-ignore", -1, 0, -1, 0, 6, 13, 1'b1);

    // reset pulse in the middle of COMPUTE
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      start = (c == 0); in_valid = 1'b1; out_ready = 1'b1;
    end
    @(negedge clk);
    chk("pre-reset busy", int'(busy), 1);
    @(posedge clk); #1;
    in_data = 1'b1; y_in = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset("mid-reset");
    @(posedge clk); #1;
    check_reset("mid-reset held");
    rst_n = 1'b1;
    apply_table();

    // single-layer instance: LOAD straight into DRAIN
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      start1 = (c == 0); in_valid = 1'b1; out_ready = 1'b1;
      in_data = 1'b0; y_in = 1'b1;
      @(negedge clk);
      if (c >= 2 && c <= 4) chk($sformatf("n1 w_addr c%0d", c), int'(w_addr1), c - 2);
      if (c == 5) chk("n1 drain slot0", int'({busy1, lyr_sel1, out_valid1}), 3'b100);
      if (c == 6) chk("n1 drain word", int'(out_valid1), 1);
      if (done1) begin
        lat = c;
        break;
      end
    end
    chk("n1 latency", lat, 9);
    $display("seq n1 latency %0d", lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
